crg_ctrl_seq: RTL and testbench
===============================

Name: crg_ctrl_seq

Overview:
- Control-side sequencer that drives the clock/reset generator's control inputs: MMCM reset, per-clock BUFGCE enables, and the clk1 BUFGMUX select.
- Runs on the free-running post-IBUF source clock, not on any MMCM output.
- Performs the MMCM reset/lock power-up sequence, then a staggered enable ramp.
- Performs glitch-safe clk1 source switching (gate off, switch select, gate on) and recovers automatically from loss of lock.

Parameters:
RST_HOLD_CYC, 16, cycles mmcm_reset is held high per reset attempt
LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before a retry
LOCK_STABLE_CYC, 64, consecutive cycles of synced lock required before enabling clocks
ENA_GAP, 4, cycles between successive enable-bit releases during the ramp
SW_GAP, 8, drain/settle cycles around a BUFGMUX select change
CNT_W, 16, width of the shared state timer; must hold the largest cycle parameter

Ports:
clk_src  in  1  free-running source clock (post-IBUF)
rst_clk_src  in  1  synchronous, active-high reset
mmcm_locked  in  1  MMCM locked, asynchronous; synchronised internally by 2 FFs into locked_s
mmcm_reset  out  1  MMCM reset request, active-high
en_req  in  4  enable requests: [0]=clk_phy, [1]=clk1, [2]=clk2, [3]=clk3
sw_req  in  1  single-cycle request to switch clk1 source
sw_sel  in  1  target clk1 select, sampled when sw_req=1
sw_ack  out  1  single-cycle pulse: switch complete or no-op
clk_en  out  4  BUFGCE enables, same bit order as en_req
clk1_sel  out  1  BUFGMUX select for clk1
ready  out  1  high only in RUN
timeout_err  out  1  sticky; set on any lock timeout
lock_loss_cnt  out  8  count of lock losses while RUN/switching, saturates at 255

Behaviour:
- All outputs are registered.
- Reset (rst_clk_src=1 at a clk_src edge) sets: state RST_HOLD, timer=0, mmcm_reset=1, clk_en=0, clk1_sel=0, ready=0, sw_ack=0, timeout_err=0, lock_loss_cnt=0, sync FFs=0.
- Reset asserted mid-operation overrides every state and value.
- RST_HOLD: mmcm_reset=1, clk_en=0. After RST_HOLD_CYC cycles go to WAIT_LOCK with timer cleared. mmcm_reset is 0 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - locked_s=1 -> STABLE, timer cleared.
  - Timer reaches LOCK_TIMEOUT-1 with no lock -> timeout_err=1, then RST_HOLD. Retries indefinitely.
- STABLE:
  - locked_s held 1 for LOCK_STABLE_CYC cycles -> RAMP.
  - locked_s=0 -> WAIT_LOCK with timer cleared. This is not counted as a lock loss.
- RAMP:
  - On the first RAMP cycle, clk_en[0] takes en_req[0].
  - Bit i takes en_req[i] i*ENA_GAP cycles after RAMP entry.
  - Bits already released track en_req with 1-cycle latency.
  - When bit 3 is released -> RUN; ready=1 on the same edge.
  - locked_s=0 during RAMP is handled as lock loss.
- RUN:
  - clk_en[i] = en_req[i] registered (1-cycle latency).
  - sw_req=1 with sw_sel==clk1_sel: sw_ack=1 on the next cycle, no other change.
  - sw_req=1 with sw_sel!=clk1_sel: latch sw_sel, ready=0 -> SW_OFF.
- SW_OFF: clk_en[1]=0 and is held 0. Other bits keep tracking. After SW_GAP cycles -> SW_SEL.
- SW_SEL: clk1_sel=latched sw_sel on entry. After SW_GAP cycles -> SW_ON.
- SW_ON (one cycle): clk_en[1]=en_req[1], sw_ack=1 -> RUN, ready=1.
- sw_req outside RUN is ignored. It is not queued and produces no ack.
- Lock loss (locked_s=0 in RAMP, RUN, SW_OFF, SW_SEL or SW_ON):
  - On the same edge: clk_en=0, ready=0, lock_loss_cnt+1 (saturating), -> RST_HOLD.
  - clk1_sel keeps its current value.
  - A pending switch is abandoned with no sw_ack.
  - Lock loss has priority over sw_req on the same cycle.
- clk1_sel never changes while clk_en[1]=1.

Test Plan:
- Release reset at cycle 0; mmcm_locked rises at cycle 30 and stays high, en_req=4'hF -> mmcm_reset falls at cycle 16; clk_en bits rise in order 0,1,2,3 at 4-cycle spacing, starting 2 sync + 64 stable cycles after lock; ready=1 with bit 3; timeout_err=0.
- mmcm_locked held 0 -> timeout_err=1 after 16+1024 cycles; mmcm_reset pulses high for 16 cycles, then retries repeatedly; clk_en stays 0.
- In RUN, sw_req with sw_sel=1 -> clk_en[1] falls next cycle; clk1_sel=1 exactly 8 cycles later; clk_en[1]=1 and sw_ack pulse 8 cycles after that; clk_en[0,2,3] unaffected throughout.
- In RUN, sw_req with sw_sel equal to clk1_sel -> sw_ack one-cycle pulse, clk_en unchanged; sw_req during RAMP -> no ack.
- Drop mmcm_locked during SW_SEL -> clk_en=0, ready=0, lock_loss_cnt=1, no sw_ack, clk1_sel keeps its current value, full re-sequence follows.
- Force 300 lock losses -> lock_loss_cnt saturates at 255; assert rst_clk_src mid-RAMP -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/crg_ctrl_seq.sv
// Clock/reset generator control sequencer: MMCM reset/lock bring-up, staggered
// BUFGCE enable ramp, glitch-safe clk1 BUFGMUX switching and lock-loss recovery.
module crg_ctrl_seq #(
    parameter int unsigned RST_HOLD_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT    = 1024,
    parameter int unsigned LOCK_STABLE_CYC = 64,
    parameter int unsigned ENA_GAP         = 4,
    parameter int unsigned SW_GAP          = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk_src,
    input  logic       rst_clk_src,
    input  logic       mmcm_locked,
    output logic       mmcm_reset,
    input  logic [3:0] en_req,
    input  logic       sw_req,
    input  logic       sw_sel,
    output logic       sw_ack,
    output logic [3:0] clk_en,
    output logic       clk1_sel,
    output logic       ready,
    output logic       timeout_err,
    output logic [7:0] lock_loss_cnt
);

    localparam int unsigned NUM_CLK = 4;
    localparam int unsigned LLC_W   = 8;

    localparam logic [CNT_W-1:0] RST_HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST   = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] SW_LAST       = CNT_W'(SW_GAP - 1);
    localparam logic [CNT_W-1:0] REL1_T        = CNT_W'(1 * ENA_GAP - 1);
    localparam logic [CNT_W-1:0] REL2_T        = CNT_W'(2 * ENA_GAP - 1);
    localparam logic [CNT_W-1:0] REL3_T        = CNT_W'((NUM_CLK - 1) * ENA_GAP - 1);
    localparam logic [LLC_W-1:0] LLC_MAX       = '1;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RAMP      = 3'd3,
        ST_RUN       = 3'd4,
        ST_SW_OFF    = 3'd5,
        ST_SW_SEL    = 3'd6,
        ST_SW_ON     = 3'd7
    } state_e;

    state_e               r_state;
    logic [CNT_W-1:0]     r_timer;
    logic                 r_lock_meta;
    logic                 r_lock_s;
    logic                 r_mmcm_reset;
    logic [NUM_CLK-1:0]   r_clk_en;
    logic                 r_clk1_sel;
    logic                 r_sw_sel_lat;
    logic                 r_ready;
    logic                 r_sw_ack;
    logic                 r_timeout_err;
    logic [LLC_W-1:0]     r_lock_loss_cnt;

    state_e               w_state_nxt;
    logic [CNT_W-1:0]     w_timer_nxt;
    logic                 w_mmcm_reset_nxt;
    logic [NUM_CLK-1:0]   w_clk_en_nxt;
    logic                 w_clk1_sel_nxt;
    logic                 w_sw_sel_lat_nxt;
    logic                 w_ready_nxt;
    logic                 w_sw_ack_nxt;
    logic                 w_timeout_err_nxt;
    logic [LLC_W-1:0]     w_lock_loss_cnt_nxt;

    logic [NUM_CLK-1:0]   w_rel_mask;
    logic [NUM_CLK-1:0]   w_en_clk1_off;
    logic                 w_clocks_live;
    logic                 w_lock_lost;

    // Two-flop synchroniser for the asynchronous MMCM lock indication
    always_ff @(posedge clk_src) begin
        if (rst_clk_src) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= mmcm_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Ramp release mask: bit i is live once i*ENA_GAP cycles have elapsed since RAMP entry
    always_comb begin
        w_rel_mask    = '0;
        w_rel_mask[0] = 1'b1;
        w_rel_mask[1] = (r_timer >= REL1_T);
        w_rel_mask[2] = (r_timer >= REL2_T);
        w_rel_mask[3] = (r_timer >= REL3_T);
    end

    assign w_en_clk1_off = en_req & 4'b1101;

    assign w_clocks_live = (r_state == ST_RAMP)   || (r_state == ST_RUN)    ||
                           (r_state == ST_SW_OFF) || (r_state == ST_SW_SEL) ||
                           (r_state == ST_SW_ON);

    assign w_lock_lost = w_clocks_live && !r_lock_s;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt         = r_state;
        w_timer_nxt         = r_timer + CNT_W'(1);
        w_mmcm_reset_nxt    = r_mmcm_reset;
        w_clk_en_nxt        = r_clk_en;
        w_clk1_sel_nxt      = r_clk1_sel;
        w_sw_sel_lat_nxt    = r_sw_sel_lat;
        w_ready_nxt         = r_ready;
        w_sw_ack_nxt        = 1'b0;
        w_timeout_err_nxt   = r_timeout_err;
        w_lock_loss_cnt_nxt = r_lock_loss_cnt;

        case (r_state)
            ST_RST_HOLD: begin
                w_mmcm_reset_nxt = 1'b1;
                w_clk_en_nxt     = '0;
                if (r_timer == RST_HOLD_LAST) begin
                    w_state_nxt      = ST_WAIT_LOCK;
                    w_timer_nxt      = '0;
                    w_mmcm_reset_nxt = 1'b0;
                end
            end

            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == LOCK_TO_LAST) begin
                    w_state_nxt       = ST_RST_HOLD;
                    w_timer_nxt       = '0;
                    w_mmcm_reset_nxt  = 1'b1;
                    w_timeout_err_nxt = 1'b1;
                end
            end

            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == STABLE_LAST) begin
                    w_state_nxt     = ST_RAMP;
                    w_timer_nxt     = '0;
                    w_clk_en_nxt    = '0;
                    w_clk_en_nxt[0] = en_req[0];
                end
            end

            ST_RAMP: begin
                w_clk_en_nxt = en_req & w_rel_mask;
                if (r_timer == REL3_T) begin
                    w_state_nxt = ST_RUN;
                    w_timer_nxt = '0;
                    w_ready_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                w_clk_en_nxt = en_req;
                w_timer_nxt  = '0;
                if (sw_req) begin
                    if (sw_sel == r_clk1_sel) begin
                        w_sw_ack_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = ST_SW_OFF;
                        w_sw_sel_lat_nxt = sw_sel;
                        w_ready_nxt      = 1'b0;
                        w_clk_en_nxt     = w_en_clk1_off;
                    end
                end
            end

            // clk1 gated off while the mux drains, then the select moves
            ST_SW_OFF: begin
                w_clk_en_nxt = w_en_clk1_off;
                if (r_timer == SW_LAST) begin
                    w_state_nxt    = ST_SW_SEL;
                    w_timer_nxt    = '0;
                    w_clk1_sel_nxt = r_sw_sel_lat;
                end
            end

            ST_SW_SEL: begin
                w_clk_en_nxt = w_en_clk1_off;
                if (r_timer == SW_LAST) begin
                    w_state_nxt  = ST_SW_ON;
                    w_timer_nxt  = '0;
                    w_clk_en_nxt = en_req;
                    w_sw_ack_nxt = 1'b1;
                end
            end

            ST_SW_ON: begin
                w_clk_en_nxt = en_req;
                w_state_nxt  = ST_RUN;
                w_timer_nxt  = '0;
                w_ready_nxt  = 1'b1;
            end

            default: begin
                w_state_nxt = ST_RST_HOLD;
                w_timer_nxt = '0;
            end
        endcase

        // Lock loss overrides everything except the clk1 select
        if (w_lock_lost) begin
            w_state_nxt      = ST_RST_HOLD;
            w_timer_nxt      = '0;
            w_mmcm_reset_nxt = 1'b1;
            w_clk_en_nxt     = '0;
            w_ready_nxt      = 1'b0;
            w_sw_ack_nxt     = 1'b0;
            if (r_lock_loss_cnt != LLC_MAX) begin
                w_lock_loss_cnt_nxt = r_lock_loss_cnt + LLC_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_src) begin
        if (rst_clk_src) begin
            r_state         <= ST_RST_HOLD;
            r_timer         <= '0;
            r_mmcm_reset    <= 1'b1;
            r_clk_en        <= '0;
            r_clk1_sel      <= 1'b0;
            r_sw_sel_lat    <= 1'b0;
            r_ready         <= 1'b0;
            r_sw_ack        <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_timer         <= w_timer_nxt;
            r_mmcm_reset    <= w_mmcm_reset_nxt;
            r_clk_en        <= w_clk_en_nxt;
            r_clk1_sel      <= w_clk1_sel_nxt;
            r_sw_sel_lat    <= w_sw_sel_lat_nxt;
            r_ready         <= w_ready_nxt;
            r_sw_ack        <= w_sw_ack_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
            r_lock_loss_cnt <= w_lock_loss_cnt_nxt;
        end
    end

    assign mmcm_reset    = r_mmcm_reset;
    assign clk_en        = r_clk_en;
    assign clk1_sel      = r_clk1_sel;
    assign ready         = r_ready;
    assign sw_ack        = r_sw_ack;
    assign timeout_err   = r_timeout_err;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_crg_ctrl_seq.sv
// Self-checking bench for crg_ctrl_seq: bring-up timing, RUN vector table with
// scoreboard, clk1 switching, lock loss, lock timeout, counter saturation, reset.
module tb_crg_ctrl_seq;

    localparam int unsigned RST_HOLD_CYC    = 16;
    localparam int unsigned LOCK_TIMEOUT    = 1024;
    localparam int unsigned LOCK_STABLE_CYC = 64;
    localparam int unsigned ENA_GAP         = 4;
    localparam int unsigned SW_GAP          = 8;

    logic       clk_src = 1'b0;
    logic       rst_clk_src = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       mmcm_reset;
    logic [3:0] en_req = 4'h0;
    logic       sw_req = 1'b0;
    logic       sw_sel = 1'b0;
    logic       sw_ack;
    logic [3:0] clk_en;
    logic       clk1_sel;
    logic       ready;
    logic       timeout_err;
    logic [7:0] lock_loss_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ack_total = 0;

    typedef struct {
        logic [3:0] en;
        logic       req;
        logic       sel;
        logic [3:0] exp_en;
        logic       exp_ack;
    } vec_t;

    typedef struct {
        logic [3:0] en;
        logic       ack;
        logic       sel;
        logic       rdy;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    crg_ctrl_seq #(
        .RST_HOLD_CYC    (RST_HOLD_CYC),
        .LOCK_TIMEOUT    (LOCK_TIMEOUT),
        .LOCK_STABLE_CYC (LOCK_STABLE_CYC),
        .ENA_GAP         (ENA_GAP),
        .SW_GAP          (SW_GAP),
        .CNT_W           (16)
    ) dut (
        .clk_src       (clk_src),
        .rst_clk_src   (rst_clk_src),
        .mmcm_locked   (mmcm_locked),
        .mmcm_reset    (mmcm_reset),
        .en_req        (en_req),
        .sw_req        (sw_req),
        .sw_sel        (sw_sel),
        .sw_ack        (sw_ack),
        .clk_en        (clk_en),
        .clk1_sel      (clk1_sel),
        .ready         (ready),
        .timeout_err   (timeout_err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk_src = ~clk_src;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk_src);
        #1;
        cyc++;
        if (sw_ack === 1'b1) ack_total++;
    endtask

    task automatic do_reset();
        rst_clk_src = 1'b1;
        repeat (3) tick();
        rst_clk_src = 1'b0;
        cyc = 0;
        ack_total = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mmcm_reset"}, 32'(mmcm_reset), 32'd1);
        check({tag, "_clk_en"}, 32'(clk_en), 32'd0);
        check({tag, "_clk1_sel"}, 32'(clk1_sel), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_sw_ack"}, 32'(sw_ack), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_lock_loss_cnt"}, 32'(lock_loss_cnt), 32'd0);
    endtask

    initial begin
        // RUN-state vectors: clk_en follows en_req one cycle later; same-select requests ack
        vecs[0] = '{4'hF, 1'b0, 1'b0, 4'hF, 1'b0};
        vecs[1] = '{4'hA, 1'b0, 1'b0, 4'hA, 1'b0};
        vecs[2] = '{4'h5, 1'b1, 1'b0, 4'h5, 1'b1};
        vecs[3] = '{4'h0, 1'b0, 1'b1, 4'h0, 1'b0};
        vecs[4] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b1};
        vecs[5] = '{4'hF, 1'b1, 1'b0, 4'hF, 1'b1};
        vecs[6] = '{4'h3, 1'b0, 1'b0, 4'h3, 1'b0};
        vecs[7] = '{4'hF, 1'b0, 1'b0, 4'hF, 1'b0};

        en_req = 4'hF;
        do_reset();
        check_reset_vals("rst");

        begin : t_powerup
            int t_rst_fall;
            int t_en[4];
            int t_rdy;
            t_rst_fall = -1;
            t_rdy = -1;
            for (int b = 0; b < 4; b++) t_en[b] = -1;
            for (int n = 1; n <= 200; n++) begin
                if (n == 30) mmcm_locked = 1'b1;
                tick();
                if (t_rst_fall < 0 && mmcm_reset === 1'b0) t_rst_fall = n;
                for (int b = 0; b < 4; b++)
                    if (t_en[b] < 0 && clk_en[b] === 1'b1) t_en[b] = n;
                if (t_rdy < 0 && ready === 1'b1) t_rdy = n;
                if (t_rdy >= 0) break;
            end
            check("pu_mmcm_reset_fall", 32'(t_rst_fall), 32'(RST_HOLD_CYC));
            for (int b = 0; b < 4; b++)
                check($sformatf("pu_clk_en%0d_rise", b), 32'(t_en[b]),
                      32'(30 + 2 + LOCK_STABLE_CYC + b * ENA_GAP));
            check("pu_ready_rise", 32'(t_rdy), 32'(30 + 2 + LOCK_STABLE_CYC + 3 * ENA_GAP));
            check("pu_timeout_err", 32'(timeout_err), 32'd0);
        end

        begin : t_run_table
            exp_t e;
            exp_t e_push;
            for (int i = 0; i < 8; i++) begin
                en_req = vecs[i].en;
                sw_req = vecs[i].req;
                sw_sel = vecs[i].sel;
                e_push.en  = vecs[i].exp_en;
                e_push.ack = vecs[i].exp_ack;
                e_push.sel = 1'b0;
                e_push.rdy = 1'b1;
                sb.push_back(e_push);
                tick();
                e = sb.pop_front();
                check($sformatf("run_vec%0d", i), 32'({clk_en, sw_ack, clk1_sel, ready}),
                      32'({e.en, e.ack, e.sel, e.rdy}));
            end
            sw_req = 1'b0;
            sw_sel = 1'b0;
            en_req = 4'hF;
            tick();
        end

        begin : t_switch
            int t_sel;
            int t_on;
            int t_rdy;
            int acks;
            int ack_at;
            int other_bad;
            t_sel = -1; t_on = -1; t_rdy = -1; acks = 0; ack_at = -1; other_bad = 0;
            sw_req = 1'b1;
            sw_sel = 1'b1;
            tick();
            sw_req = 1'b0;
            check("sw_clk1_gated", 32'(clk_en), 32'hD);
            check("sw_ready_low", 32'(ready), 32'd0);
            for (int n = 1; n <= 30; n++) begin
                // A request while switching must be ignored
                if (n == 3) begin
                    sw_req = 1'b1;
                    sw_sel = 1'b0;
                end else begin
                    sw_req = 1'b0;
                end
                tick();
                if (clk_en[0] !== 1'b1 || clk_en[2] !== 1'b1 || clk_en[3] !== 1'b1) other_bad++;
                if (t_sel < 0 && clk1_sel === 1'b1) t_sel = n;
                if (t_on < 0 && clk_en[1] === 1'b1) t_on = n;
                if (t_rdy < 0 && ready === 1'b1) t_rdy = n;
                if (sw_ack === 1'b1) begin
                    acks++;
                    ack_at = n;
                end
            end
            check("sw_sel_change", 32'(t_sel), 32'(SW_GAP));
            check("sw_clk1_reenable", 32'(t_on), 32'(2 * SW_GAP));
            check("sw_ack_count", 32'(acks), 32'd1);
            check("sw_ack_time", 32'(ack_at), 32'(2 * SW_GAP));
            check("sw_ready_back", 32'(t_rdy), 32'(2 * SW_GAP + 1));
            check("sw_other_bits", 32'(other_bad), 32'd0);
            check("sw_final_sel", 32'(clk1_sel), 32'd1);
        end

        begin : t_lockloss
            int acks0;
            bit ramp_req_done;
            acks0 = ack_total;
            ramp_req_done = 1'b0;
            sw_req = 1'b1;
            sw_sel = 1'b0;
            tick();
            sw_req = 1'b0;
            for (int n = 1; n <= 400; n++) begin
                if (n == 10) mmcm_locked = 1'b0;
                if (n == 16) mmcm_locked = 1'b1;
                sw_req = 1'b0;
                // Request a switch while the re-sequence is ramping; it must be dropped
                if (n > 12 && !ramp_req_done && clk_en[0] === 1'b1 && ready === 1'b0) begin
                    sw_req = 1'b1;
                    sw_sel = 1'b1;
                    ramp_req_done = 1'b1;
                end
                tick();
                if (n == SW_GAP) check("ll_sel_at_sw_sel", 32'(clk1_sel), 32'd0);
                if (n == 12) begin
                    check("ll_clk_en", 32'(clk_en), 32'd0);
                    check("ll_ready", 32'(ready), 32'd0);
                    check("ll_cnt", 32'(lock_loss_cnt), 32'd1);
                    check("ll_mmcm_reset", 32'(mmcm_reset), 32'd1);
                    check("ll_sel_kept", 32'(clk1_sel), 32'd0);
                end
                if (n > 12 && ready === 1'b1) break;
            end
            sw_req = 1'b0;
            check("ll_resequenced", 32'(ready), 32'd1);
            repeat (20) tick();
            check("ll_no_ack", 32'(ack_total - acks0), 32'd0);
            check("ll_ramp_req_ignored", 32'(clk1_sel), 32'd0);
            check("ll_cnt_final", 32'(lock_loss_cnt), 32'd1);
        end

        begin : t_timeout
            int en_bad;
            int rises;
            logic prev_rst;
            mmcm_locked = 1'b0;
            do_reset();
            en_bad = 0;
            rises = 0;
            prev_rst = mmcm_reset;
            for (int n = 1; n <= 2100; n++) begin
                tick();
                if (clk_en !== 4'h0) en_bad++;
                if (mmcm_reset === 1'b1 && prev_rst === 1'b0) rises++;
                prev_rst = mmcm_reset;
                if (n == RST_HOLD_CYC + LOCK_TIMEOUT - 1) begin
                    check("to_err_before", 32'(timeout_err), 32'd0);
                    check("to_rst_before", 32'(mmcm_reset), 32'd0);
                end
                if (n == RST_HOLD_CYC + LOCK_TIMEOUT) begin
                    check("to_err_set", 32'(timeout_err), 32'd1);
                    check("to_rst_retry", 32'(mmcm_reset), 32'd1);
                end
                if (n == 2 * RST_HOLD_CYC + LOCK_TIMEOUT - 1)
                    check("to_rst_hold_end", 32'(mmcm_reset), 32'd1);
                if (n == 2 * RST_HOLD_CYC + LOCK_TIMEOUT)
                    check("to_rst_release2", 32'(mmcm_reset), 32'd0);
                if (n == 2 * (RST_HOLD_CYC + LOCK_TIMEOUT))
                    check("to_rst_retry2", 32'(mmcm_reset), 32'd1);
            end
            check("to_clk_en_low", 32'(en_bad), 32'd0);
            check("to_retry_count", 32'(rises), 32'd2);
            check("to_err_sticky", 32'(timeout_err), 32'd1);
        end

        begin : t_saturate
            mmcm_locked = 1'b1;
            en_req = 4'hF;
            do_reset();
            for (int i = 0; i < 300; i++) begin
                for (int k = 0; k < 400 && clk_en[0] !== 1'b1; k++) tick();
                check("sat_ramp_reached", 32'(clk_en[0]), 32'd1);
                if (clk_en[0] !== 1'b1) break;
                mmcm_locked = 1'b0;
                tick();
                mmcm_locked = 1'b1;
                for (int k = 0; k < 10 && mmcm_reset !== 1'b1; k++) tick();
                check("sat_loss_detected", 32'(mmcm_reset), 32'd1);
                if (i == 9) check("sat_cnt_10", 32'(lock_loss_cnt), 32'd10);
            end
            check("sat_cnt_255", 32'(lock_loss_cnt), 32'd255);

            for (int k = 0; k < 400 && clk_en[0] !== 1'b1; k++) tick();
            check("midramp_in_ramp", 32'({clk_en[0], ready}), 32'b10);
            rst_clk_src = 1'b1;
            tick();
            check_reset_vals("midramp");
            rst_clk_src = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
